// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage hazard/stall control logic.
package pipe_pkg;
  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    IWAIT = 2'd2,
    DWAIT = 2'd3
  } stall_state_e;
endpackage

// File: rtl/load_use_detect.sv
// Load-use compare: a load in EX feeds a source of the instruction in ID.
module load_use_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_use
);
  import pipe_pkg::*;

  // r0 is hardwired, so a load targeting it never creates a dependence
  assign load_use = ex_mem_read && (ex_rt != REG_AW'(ZERO_REG)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller: per-stage enables, flushes and bubbles, plus a
// wait-state tracker with miss watchdog and stall performance counter.
module pipeline_stall_ctrl #(
  parameter int REG_AW       = pipe_pkg::REG_AW,
  parameter int CNT_W        = 8,
  parameter int MISS_TIMEOUT = 200,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IDEXMemRead,
  input  logic [REG_AW-1:0] IDEXRegRt,
  input  logic [REG_AW-1:0] IFIDRegRs,
  input  logic [REG_AW-1:0] IFIDRegRt,
  input  logic              IFIDUsesRt,
  input  logic              branchTaken,
  input  logic              icacheReq,
  input  logic              icacheReady,
  input  logic              dcacheReq,
  input  logic              dcacheReady,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              ifidFlush,
  output logic              idexWrite,
  output logic              idexBubble,
  output logic              exmemWrite,
  output logic              memwbBubble,
  output logic              icacheAbort,
  output logic [1:0]        stallState,
  output logic              missTimeout,
  output logic [PERF_W-1:0] stallCount
);
  import pipe_pkg::*;

  logic load_use, d_miss, i_miss, in_wait_d;
  stall_state_e state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              miss_timeout_q, miss_timeout_d;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .ex_mem_read (IDEXMemRead),
    .ex_rt       (IDEXRegRt),
    .id_rs       (IFIDRegRs),
    .id_rt       (IFIDRegRt),
    .id_uses_rt  (IFIDUsesRt),
    .load_use    (load_use)
  );

  assign d_miss = dcacheReq && !dcacheReady;
  assign i_miss = icacheReq && !icacheReady;

  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexWrite   = 1'b1;
    idexBubble  = 1'b0;
    exmemWrite  = 1'b1;
    memwbBubble = 1'b0;
    icacheAbort = 1'b0;
    state_d     = RUN;
    if (d_miss) begin
      // whole front of the pipe freezes; pending branch/load-use wait their turn
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexWrite   = 1'b0;
      exmemWrite  = 1'b0;
      memwbBubble = 1'b1;
      state_d     = DWAIT;
    end else if (branchTaken) begin
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      icacheAbort = i_miss;
    end else if (load_use) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      state_d    = LDUSE;
    end else if (i_miss) begin
      pcWrite   = 1'b0;
      ifidFlush = 1'b1;
      state_d   = IWAIT;
    end
    if (!rst_n) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      ifidFlush   = 1'b1;
      idexWrite   = 1'b0;
      idexBubble  = 1'b1;
      exmemWrite  = 1'b0;
      memwbBubble = 1'b1;
      icacheAbort = 1'b0;
    end
  end

  always_comb begin
    in_wait_d = (state_d == DWAIT) || (state_d == IWAIT);
    wait_cnt_d = '0;
    // a fresh wait (including DWAIT->IWAIT) restarts the count
    if (in_wait_d && (state_d == state_q))
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    miss_timeout_d = miss_timeout_q ||
                     (in_wait_d && (wait_cnt_d == CNT_W'(MISS_TIMEOUT)));
    stall_count_d = stall_count_q + {{(PERF_W-1){1'b0}}, !pcWrite};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      miss_timeout_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      miss_timeout_q <= miss_timeout_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign stallState  = state_q;
  assign missTimeout = miss_timeout_q;
  assign stallCount  = stall_count_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Vector-table bench for pipeline_stall_ctrl with an expected-output queue
// and a small reference model of wait count, watchdog and stall counter.
module tb_pipeline_stall_ctrl;
  import pipe_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic IDEXMemRead, IFIDUsesRt, branchTaken, icacheReq, icacheReady, dcacheReq, dcacheReady;
  logic [3:0] IDEXRegRt, IFIDRegRs, IFIDRegRt;
  logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, memwbBubble, icacheAbort;
  logic [1:0] stallState;
  logic missTimeout;
  logic [15:0] stallCount;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.REG_AW(4), .CNT_W(8), .MISS_TIMEOUT(TO), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEXMemRead(IDEXMemRead), .IDEXRegRt(IDEXRegRt),
    .IFIDRegRs(IFIDRegRs), .IFIDRegRt(IFIDRegRt), .IFIDUsesRt(IFIDUsesRt),
    .branchTaken(branchTaken),
    .icacheReq(icacheReq), .icacheReady(icacheReady),
    .dcacheReq(dcacheReq), .dcacheReady(dcacheReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexWrite(idexWrite), .idexBubble(idexBubble), .exmemWrite(exmemWrite),
    .memwbBubble(memwbBubble), .icacheAbort(icacheAbort),
    .stallState(stallState), .missTimeout(missTimeout), .stallCount(stallCount)
  );

  // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, memwbBubble, icacheAbort}
  localparam logic [7:0] O_DEF = 8'b1101_0100;
  localparam logic [7:0] O_DM  = 8'b0000_0010;
  localparam logic [7:0] O_BR  = 8'b1111_1100;
  localparam logic [7:0] O_BRA = 8'b1111_1101;
  localparam logic [7:0] O_LU  = 8'b0001_1100;
  localparam logic [7:0] O_IM  = 8'b0111_0100;
  localparam logic [7:0] O_RST = 8'b0010_1010;

  typedef struct {
    logic ld; logic [3:0] ert, rs, rt; logic us, br, ireq, irdy, dreq, drdy;
    logic [7:0] o; logic [1:0] st;
  } vec_t;
  typedef struct { logic [7:0] o; logic [1:0] st; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [1:0] m_st = 2'd0;
  int m_wc = 0, m_cnt = 0;
  logic m_mto = 1'b0;

  function automatic vec_t mk(input logic ld, input logic [3:0] ert, rs, rt,
                              input logic us, br, ireq, irdy, dreq, drdy,
                              input logic [7:0] o, input logic [1:0] st);
    vec_t v;
    v.ld = ld; v.ert = ert; v.rs = rs; v.rt = rt; v.us = us; v.br = br;
    v.ireq = ireq; v.irdy = irdy; v.dreq = dreq; v.drdy = drdy; v.o = o; v.st = st;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, memwbBubble, icacheAbort};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    IDEXMemRead = v.ld; IDEXRegRt = v.ert; IFIDRegRs = v.rs; IFIDRegRt = v.rt;
    IFIDUsesRt = v.us; branchTaken = v.br; icacheReq = v.ireq; icacheReady = v.irdy;
    dcacheReq = v.dreq; dcacheReady = v.drdy;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic [1:0] prev;
    @(negedge clk);
    drive(v);
    sb.push_back('{o: v.o, st: v.st});
    #1;
    e = sb.pop_front();
    check("outs", {24'd0, outs()}, {24'd0, e.o});
    @(posedge clk);
    prev = m_st;
    m_st = e.st;
    if ((m_st == 2'd2 || m_st == 2'd3) && m_st == prev) m_wc = (m_wc == 255) ? 255 : m_wc + 1;
    else m_wc = 0;
    if ((m_st == 2'd2 || m_st == 2'd3) && m_wc == TO) m_mto = 1'b1;
    if (!e.o[7]) m_cnt = (m_cnt + 1) % 65536;
    #1;
    check("stallState", {30'd0, stallState}, {30'd0, m_st});
    check("stallCount", {16'd0, stallCount}, m_cnt[31:0]);
    check("missTimeout", {31'd0, missTimeout}, {31'd0, m_mto});
  endtask

  task automatic model_reset();
    m_st = 2'd0; m_wc = 0; m_cnt = 0; m_mto = 1'b0;
  endtask

  initial begin
    vec_t idle, dm;
    idle = mk(0,0,0,0,0,0,0,0,0,0,O_DEF,2'd0);
    dm   = mk(0,0,0,0,0,0,0,0,1,0,O_DM,2'd3);
    drive(idle);
    #1;
    check("rst_outs", {24'd0, outs()}, {24'd0, O_RST});
    check("rst_state", {30'd0, stallState}, 32'd0);
    check("rst_count", {16'd0, stallCount}, 32'd0);
    check("rst_mto", {31'd0, missTimeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back(idle);
    tbl.push_back(mk(1,5,5,0,0,0,0,0,0,0,O_LU,2'd1));   // load-use on rs
    tbl.push_back(idle);                               // load has advanced
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_DEF,2'd0)); // r0 never hazards
    tbl.push_back(mk(1,7,3,7,0,0,0,0,0,0,O_DEF,2'd0)); // rt match, rt unused
    tbl.push_back(mk(1,7,3,7,1,0,0,0,0,0,O_LU,2'd1));  // rt match, rt used
    tbl.push_back(mk(1,5,5,0,0,1,0,0,1,0,O_DM,2'd3));  // 3-cycle D-miss holds branch
    tbl.push_back(mk(1,5,5,0,0,1,0,0,1,0,O_DM,2'd3));
    tbl.push_back(mk(1,5,5,0,0,1,0,0,1,0,O_DM,2'd3));
    tbl.push_back(mk(1,5,5,0,0,1,0,0,1,1,O_BR,2'd0));  // release: branch acts
    tbl.push_back(mk(0,0,0,0,0,1,1,0,0,0,O_BRA,2'd0)); // branch during I-miss
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,0,O_IM,2'd2));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,0,0,O_DEF,2'd0)); // I-hit
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1,0,O_DM,2'd3));  // both miss: D wins
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1,0,O_DM,2'd3));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1,1,O_IM,2'd2));  // DWAIT -> IWAIT
    tbl.push_back(idle);
    tbl.push_back(mk(1,5,5,0,0,0,0,0,1,0,O_DM,2'd3));
    tbl.push_back(mk(1,5,5,0,0,0,1,0,0,0,O_LU,2'd1));  // load-use over I-miss
    tbl.push_back(mk(1,5,5,0,0,1,0,0,0,0,O_BR,2'd0));  // branch flushes load-use
    tbl.push_back(idle);
    foreach (tbl[i]) apply(tbl[i]);

    // watchdog: flag rises on the 5th wait cycle and is sticky
    for (int i = 0; i < 10; i++) begin
      apply(dm);
      if (i == 3) check("wdog_before", {31'd0, missTimeout}, 32'd0);
      if (i == 4) check("wdog_rise", {31'd0, missTimeout}, 32'd1);
    end
    apply(idle);
    apply(idle);
    check("wdog_sticky", {31'd0, missTimeout}, 32'd1);

    // async reset in the middle of a D-miss
    apply(dm);
    apply(dm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_outs", {24'd0, outs()}, {24'd0, O_RST});
    check("amid_state", {30'd0, stallState}, 32'd0);
    check("amid_count", {16'd0, stallCount}, 32'd0);
    check("amid_mto", {31'd0, missTimeout}, 32'd0);
    model_reset();
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle);
    apply(tbl[1]);
    apply(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
